nt_subckt_eval_sched: RTL and testbench
=======================================

Name: nt_subckt_eval_sched

Overview:
- Round-robin scheduler sharing one pipelined Nt-node test subcircuit between NREQ requesters.
- Each cycle it accepts at most one input vector and drives it onto the shared subcircuit inputs.
- It tracks the requester ID through the subcircuit's fixed latency and returns the sampled output bit tagged with that ID.
- It sits between the trojan-detection stimulus generators and one subcircuit instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- VEC_W, 5, width of the subcircuit data-input vector; bit mapping is fixed by top-level integration.
- LAT, 2, clock edges from the dp_valid cycle to the edge that samples dp_out (1..4).
- IDW, 2, resp_id width; must equal clog2(NREQ).

Ports:
- I1470  in   1            clock, rising edge.
- I1477  in   1            reset, asynchronous, active-high.
- en     in   1            start request; IDLE->RUN.
- stop   in   1            drain request; RUN->DRAIN.
- req_valid  in   NREQ         per-requester vector valid.
- req_vec    in   NREQ*VEC_W   packed vectors; requester i occupies bits [i*VEC_W +: VEC_W].
- req_ready  out  NREQ         one-hot grant, combinational; transfer happens when req_valid[i] & req_ready[i].
- dp_vec     out  VEC_W        registered vector to the subcircuit.
- dp_valid   out  1            registered; dp_vec is a live sample.
- dp_out     in   1            subcircuit output.
- resp_valid out  1            registered response strobe.
- resp_id    out  IDW          requester that owns resp_bit.
- resp_bit   out  1            dp_out sampled LAT edges after the issuing dp_valid.
- busy       out  1            high when state != IDLE or any pipeline slot is occupied.
- state      out  2            00 IDLE, 01 RUN, 10 DRAIN.

Behaviour:
- Reset values: state=IDLE, req_ready=0, dp_vec=0, dp_valid=0, resp_valid=0, resp_id=0, resp_bit=0, busy=0, rr_ptr=NREQ-1.
- Reset also clears all LAT ID/valid pipeline slots. A reset mid-operation discards in-flight work; no response is ever emitted for it.
- FSM transitions:
  - IDLE: en=1 & stop=0 -> RUN. If en and stop are high together, stay IDLE. stop alone is ignored.
  - RUN: stop=1 -> DRAIN, evaluated on the same edge as any grant; a grant in that cycle still completes. en is ignored.
  - DRAIN: no grants. When all pipeline slots are empty and no dp_valid is pending -> IDLE. en is ignored.
- Arbitration (RUN only): search starts at rr_ptr+1 modulo NREQ; the first i with req_valid[i]=1 gets req_ready[i]=1.
  - rr_ptr updates to i only on a completed transfer.
  - No valid requests: req_ready=0 and rr_ptr holds.
- Issue timing:
  - Transfer at edge E: dp_vec<=req_vec[i], dp_valid<=1 at E, and ID i enters slot 0.
  - No transfer at E: dp_valid<=0 and dp_vec holds its last value.
- Response timing:
  - At edge E+LAT: resp_valid<=1, resp_id<=i, resp_bit<=dp_out as present before E+LAT.
  - Otherwise resp_valid<=0; resp_id and resp_bit hold.
  - Back-to-back issues produce back-to-back responses in issue order with no bubbles.
- Responses have no backpressure; consumers must accept every resp_valid.
- busy must stay high until the cycle after the last resp_valid of a drain.
- If req_valid[i] drops while req_ready[i]=1, no transfer occurs and rr_ptr does not move.

Optional Feature:
- Macro: NT_SCHED_CHECK_EN.
- With the macro defined:
  - Extra input req_exp[NREQ] carries the expected output bit per requester; it is captured on transfer and piped alongside the ID.
  - Extra output resp_mismatch is asserted with resp_valid when resp_bit != the expected bit.
  - Extra output mismatch_cnt[7:0] counts mismatches, saturates at 255, resets to 0 on I1477, and is not cleared by state transitions.
- Without the macro: none of these ports exist, and the expected-bit pipeline is not built.

Test Plan:
- Reset held, all inputs toggling -> every output at its reset value and state=00. Release, pulse en -> state=01 next edge.
- RUN, LAT=2, only req 2 valid with vec 5'h15, dp_out forced 1 -> dp_valid one cycle after grant; 2 edges later resp_valid=1, resp_id=2, resp_bit=1.
- All four requests valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 consecutive responses with IDs in the same order.
- stop asserted in the same cycle as a grant to req 1 -> that response still returns; no further grants; state 10 -> 00 exactly after the last resp_valid; busy falls one cycle later.
- Reset pulsed with 2 vectors in flight -> no resp_valid afterwards; rr_ptr=NREQ-1, so the first post-reset grant goes to req 0.
- NT_SCHED_CHECK_EN defined, req_exp=0, dp_out=1 for 300 responses -> resp_mismatch high on each response; mismatch_cnt saturates at 255.

Source files
------------

// File: rtl/nt_subckt_eval_sched_if.sv
// Request, subcircuit and response signals of nt_subckt_eval_sched.
// The NT_SCHED_CHECK_EN macro adds the expected-bit and mismatch signals.
interface nt_subckt_eval_sched_if #(
  parameter int NREQ  = 4,
  parameter int VEC_W = 5,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*VEC_W-1:0] req_vec;
  logic [NREQ-1:0]       req_ready;
  logic [VEC_W-1:0]      dp_vec;
  logic                  dp_valid;
  logic                  dp_out;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic                  resp_bit;
`ifdef NT_SCHED_CHECK_EN
  logic [NREQ-1:0]       req_exp;
  logic                  resp_mismatch;
  logic [7:0]            mismatch_cnt;

  modport master (
    output req_valid, req_vec, dp_out, req_exp,
    input  req_ready, dp_vec, dp_valid, resp_valid, resp_id, resp_bit,
    input  resp_mismatch, mismatch_cnt
  );
  modport slave (
    input  req_valid, req_vec, dp_out, req_exp,
    output req_ready, dp_vec, dp_valid, resp_valid, resp_id, resp_bit,
    output resp_mismatch, mismatch_cnt
  );
`else
  modport master (
    output req_valid, req_vec, dp_out,
    input  req_ready, dp_vec, dp_valid, resp_valid, resp_id, resp_bit
  );
  modport slave (
    input  req_valid, req_vec, dp_out,
    output req_ready, dp_vec, dp_valid, resp_valid, resp_id, resp_bit
  );
`endif
endinterface

// File: rtl/nt_subckt_eval_sched.sv
// Round-robin scheduler sharing one pipelined subcircuit between NREQ requesters.
// Optional expected-bit checking is built when NT_SCHED_CHECK_EN is defined.
module nt_subckt_eval_sched #(
  parameter int NREQ  = 4,
  parameter int VEC_W = 5,
  parameter int LAT   = 2,
  parameter int IDW   = 2
) (
  input  logic                   I1470,
  input  logic                   I1477,
  input  logic                   en,
  input  logic                   stop,
  nt_subckt_eval_sched_if.slave  bus,
  output logic                   busy,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]         grant_s;
  logic [IDW-1:0]          gidx_s;
  logic [IDW-1:0]          idx_s;
  logic [IDW:0]            sum_s;
  logic                    hit_s;
  logic                    xfer_s;
  logic [VEC_W-1:0]        vec_sel_s;
  logic [VEC_W-1:0]        dp_vec_q, dp_vec_d;
  logic                    dp_valid_q, dp_valid_d;
  logic [LAT-1:0]          slot_v_q, slot_v_d;
  logic [LAT-1:0][IDW-1:0] slot_id_q, slot_id_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [IDW-1:0]          resp_id_q, resp_id_d;
  logic                    resp_bit_q, resp_bit_d;
  logic                    busy_q, busy_d;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    idx_s   = '0;
    sum_s   = '0;
    hit_s   = 1'b0;
    xfer_s  = 1'b0;
    if (state_q == ST_RUN) begin
      for (int k = 1; k <= NREQ; k++) begin
        sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
        sum_s = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
        idx_s = sum_s[IDW-1:0];
        hit_s = ~xfer_s & bus.req_valid[idx_s];
        if (hit_s) begin
          grant_s[idx_s] = 1'b1;
          gidx_s         = idx_s;
          xfer_s         = 1'b1;
        end else begin
          gidx_s = gidx_s;
        end
      end
    end else begin
      xfer_s = 1'b0;
    end
  end

  always_comb begin
    vec_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      vec_sel_s = vec_sel_s | ({VEC_W{grant_s[i]}} & bus.req_vec[i*VEC_W +: VEC_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (en && !stop) ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = stop ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = ((slot_v_q == '0) && !dp_valid_q) ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Slot k holds the ID issued k edges ago; the last slot feeds the response.
  always_comb begin
    rr_ptr_d     = xfer_s ? gidx_s : rr_ptr_q;
    dp_valid_d   = xfer_s;
    dp_vec_d     = xfer_s ? vec_sel_s : dp_vec_q;
    slot_v_d     = slot_v_q;
    slot_id_d    = slot_id_q;
    slot_v_d[0]  = xfer_s;
    slot_id_d[0] = gidx_s;
    for (int k = 1; k < LAT; k++) begin
      slot_v_d[k]  = slot_v_q[k-1];
      slot_id_d[k] = slot_id_q[k-1];
    end
    resp_valid_d = slot_v_q[LAT-1];
    resp_id_d    = slot_v_q[LAT-1] ? slot_id_q[LAT-1] : resp_id_q;
    resp_bit_d   = slot_v_q[LAT-1] ? bus.dp_out : resp_bit_q;
    busy_d       = (state_q != ST_IDLE) | (|slot_v_q) | dp_valid_q;
  end

  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IDW'(NREQ-1);
      dp_vec_q     <= '0;
      dp_valid_q   <= 1'b0;
      slot_v_q     <= '0;
      slot_id_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_bit_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      dp_vec_q     <= dp_vec_d;
      dp_valid_q   <= dp_valid_d;
      slot_v_q     <= slot_v_d;
      slot_id_q    <= slot_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_bit_q   <= resp_bit_d;
      busy_q       <= busy_d;
    end
  end

`ifdef NT_SCHED_CHECK_EN
  logic           exp_sel_s;
  logic [LAT-1:0] slot_exp_q, slot_exp_d;
  logic           mismatch_q, mismatch_d;
  logic [7:0]     cnt_q, cnt_d;

  // Expected bit travels beside the ID; the counter saturates rather than wraps.
  always_comb begin
    exp_sel_s     = |(grant_s & bus.req_exp);
    slot_exp_d    = slot_exp_q;
    slot_exp_d[0] = exp_sel_s;
    for (int k = 1; k < LAT; k++) begin
      slot_exp_d[k] = slot_exp_q[k-1];
    end
    mismatch_d = slot_v_q[LAT-1] & (bus.dp_out ^ slot_exp_q[LAT-1]);
    cnt_d      = (mismatch_d && (cnt_q != 8'hFF)) ? (cnt_q + 8'd1) : cnt_q;
  end

  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      slot_exp_q <= '0;
      mismatch_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      slot_exp_q <= slot_exp_d;
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.resp_mismatch = mismatch_q;
  assign bus.mismatch_cnt  = cnt_q;
`endif

  assign bus.req_ready  = grant_s;
  assign bus.dp_vec     = dp_vec_q;
  assign bus.dp_valid   = dp_valid_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_bit   = resp_bit_q;
  assign busy           = busy_q;
  assign state          = state_q;

endmodule

// File: tb/tb_nt_subckt_eval_sched.sv
// Self-checking bench for nt_subckt_eval_sched against a transaction-queue model.
module tb_nt_subckt_eval_sched;
  localparam int NREQ  = 4;
  localparam int VEC_W = 5;
  localparam int LAT   = 2;
  localparam int IDW   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic [1:0] state;

  nt_subckt_eval_sched_if #(.NREQ(NREQ), .VEC_W(VEC_W), .IDW(IDW)) bus ();

  nt_subckt_eval_sched #(.NREQ(NREQ), .VEC_W(VEC_W), .LAT(LAT), .IDW(IDW)) u_dut (
    .I1470 (clk),
    .I1477 (rst),
    .en    (en),
    .stop  (stop),
    .bus   (bus),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   id;
    int   due;
    logic exp;
  } txn_t;

  // Model: state as an integer, rr pointer, and a queue of outstanding issues.
  int              m_state;
  int              m_rr;
  txn_t            m_q[$];
  logic [NREQ-1:0] e_ready, o_ready;
  logic [VEC_W-1:0] e_vec;
  logic            e_dpv, e_rv, e_rb, e_busy, e_mm;
  logic [IDW-1:0]  e_rid;
  logic [1:0]      e_state;
  int              e_cnt;

  task automatic model_reset();
    m_state = 0;
    m_rr    = NREQ - 1;
    m_q.delete();
    e_vec = '0; e_dpv = 1'b0; e_rv = 1'b0; e_rid = '0; e_rb = 1'b0;
    e_busy = 1'b0; e_state = 2'b00; e_mm = 1'b0; e_cnt = 0;
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v);
    if (m_state != 1) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, sample ready, advance the model at posedge.
  task automatic cycle(input logic i_en, input logic i_stop, input logic [NREQ-1:0] i_v,
                       input logic [NREQ*VEC_W-1:0] i_vec, input logic i_dout,
                       input logic [NREQ-1:0] i_exp);
    int   g;
    bit   busy_nx, drained;
    txn_t t;
    en = i_en; stop = i_stop; bus.req_valid = i_v; bus.req_vec = i_vec; bus.dp_out = i_dout;
`ifdef NT_SCHED_CHECK_EN
    bus.req_exp = i_exp;
`endif
    #1;
    o_ready = bus.req_ready;
    g = model_grant(i_v);
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    @(posedge clk);
    busy_nx = (m_state != 0) || (m_q.size() != 0);
    drained = (m_q.size() == 0);
    cyc++;
    e_rv = 1'b0;
    e_mm = 1'b0;
    if (m_q.size() != 0 && m_q[0].due == cyc) begin
      t = m_q.pop_front();
      e_rv  = 1'b1;
      e_rid = IDW'(t.id);
      e_rb  = i_dout;
      e_mm  = (i_dout != t.exp);
      if (e_mm && e_cnt < 255) e_cnt++;
    end
    if (g >= 0) begin
      t.id = g; t.due = cyc + LAT; t.exp = i_exp[g];
      m_q.push_back(t);
      m_rr  = g;
      e_dpv = 1'b1;
      e_vec = i_vec[g*VEC_W +: VEC_W];
    end else begin
      e_dpv = 1'b0;
    end
    case (m_state)
      0: if (i_en && !i_stop) m_state = 1;
      1: if (i_stop) m_state = 2;
      2: if (drained) m_state = 0;
      default: m_state = 0;
    endcase
    e_state = 2'(m_state);
    e_busy  = busy_nx;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; stop = 1'b0; bus.req_valid = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom); stop = 1'($urandom); bus.req_valid = 4'($urandom);
      bus.req_vec = 20'($urandom); bus.dp_out = 1'($urandom);
      @(negedge clk);
      obs = {bus.req_ready, bus.dp_valid, bus.dp_vec, bus.resp_valid, bus.resp_id,
             bus.resp_bit, busy, state, 9'd0};
      total++;
      if (obs !== 26'd0) begin
        bad++;
        $display("FAIL reset_values got=%h exp=0", obs);
      end
    end
    model_reset();
    rst = 1'b0;
    cycle(1'b1, 1'b0, 4'b0000, 20'd0, 1'b0, 4'b0000);
    total++;
    if (state !== 2'b01) begin
      bad++;
      $display("FAIL reset_en_to_run got=%b exp=01", state);
    end
  endtask

  task automatic test_single();
    logic [NREQ*VEC_W-1:0] v;
    v = 20'($urandom);
    v[2*VEC_W +: VEC_W] = 5'h15;
    cycle(1'b0, 1'b0, 4'b0100, v, 1'b1, 4'b0000);
    total++;
    if (o_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b exp=0100", o_ready);
    end
    total++;
    if ({bus.dp_valid, bus.dp_vec} !== {1'b1, 5'h15}) begin
      bad++; $display("FAIL single_issue got=%b/%h exp=1/15", bus.dp_valid, bus.dp_vec);
    end
    cycle(1'b0, 1'b0, 4'b0000, v, 1'b1, 4'b0000);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_early_resp got=%b exp=0", bus.resp_valid);
    end
    cycle(1'b0, 1'b0, 4'b0000, v, 1'b1, 4'b0000);
    total++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_bit} !== {1'b1, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL single_resp got=%b/%0d/%b exp=1/2/1", bus.resp_valid, bus.resp_id, bus.resp_bit);
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1'b0, 1'b0, 4'b0010, 20'($urandom), 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 4'b1000, 20'($urandom), 1'b0, 4'b0000);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 4'b0000, 20'd0, 1'b1, 4'b0000);
      total++;
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL inflight_discard got=%b/%b exp=0/0", bus.resp_valid, busy);
      end
    end
    cycle(1'b1, 1'b0, 4'b0000, 20'd0, 1'b0, 4'b0000);
  endtask

  task automatic test_round_robin();
    logic [12:0] obs, exp;
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 1'b0, (j < 8) ? 4'b1111 : 4'b0000, 20'($urandom), 1'($urandom), 4'b0000);
      if (j < 8) begin
        total++;
        if (o_ready !== 4'(1 << (j % 4))) begin
          bad++; $display("FAIL rr_order[%0d] got=%b exp=%b", j, o_ready, 4'(1 << (j % 4)));
        end
      end
      total++;
      if (bus.resp_valid !== (j >= 2) || (j >= 2 && bus.resp_id !== 2'((j - 2) % 4))) begin
        bad++;
        $display("FAIL rr_resp[%0d] got=%b/%0d exp=%b/%0d", j, bus.resp_valid, bus.resp_id,
                 (j >= 2), (j - 2) % 4);
      end
      obs = {bus.dp_valid, bus.dp_vec, bus.resp_valid, bus.resp_id, bus.resp_bit, busy, state};
      exp = {e_dpv, e_vec, e_rv, e_rid, e_rb, e_busy, e_state};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL rr_model[%0d] got=%h exp=%h", j, obs, exp);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    cycle(1'b1, 1'b0, 4'b0000, 20'd0, 1'b0, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0010, 20'($urandom), 1'b0, 4'b0000);
    total++;
    if (o_ready !== 4'b0010 || state !== 2'b10) begin
      bad++; $display("FAIL drain_grant got=%b/%b exp=0010/10", o_ready, state);
    end
    for (int j = 1; j <= 5; j++) begin
      cycle(1'b0, 1'b0, 4'b1111, 20'($urandom), 1'b1, 4'b0000);
      total++;
      if (o_ready !== 4'b0000 || bus.resp_valid !== (j == 2) ||
          (j == 2 && {bus.resp_id, bus.resp_bit} !== {2'd1, 1'b1}) ||
          state !== ((j >= 3) ? 2'b00 : 2'b10) || busy !== (j <= 3)) begin
        bad++;
        $display("FAIL drain_step[%0d] got=rdy%b rv%b id%0d st%b busy%b", j, o_ready,
                 bus.resp_valid, bus.resp_id, state, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] obs, exp;
    do_reset();
    for (int j = 0; j < 500; j++) begin
      cycle(($urandom % 4) == 0, ($urandom % 16) == 0, 4'($urandom), 20'($urandom),
            1'($urandom), 4'($urandom));
      total++;
      if (o_ready !== e_ready) begin
        bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", j, o_ready, e_ready);
      end
      obs = {bus.dp_valid, bus.dp_vec, bus.resp_valid, bus.resp_id, bus.resp_bit, busy, state};
      exp = {e_dpv, e_vec, e_rv, e_rid, e_rb, e_busy, e_state};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL rand_model[%0d] got=%h exp=%h", j, obs, exp);
      end
`ifdef NT_SCHED_CHECK_EN
      total++;
      if ({bus.resp_mismatch, bus.mismatch_cnt} !== {e_mm, 8'(e_cnt)}) begin
        bad++;
        $display("FAIL rand_check[%0d] got=%b/%0d exp=%b/%0d", j, bus.resp_mismatch,
                 bus.mismatch_cnt, e_mm, e_cnt);
      end
`endif
    end
  endtask

`ifdef NT_SCHED_CHECK_EN
  task automatic test_mismatch();
    do_reset();
    cycle(1'b1, 1'b0, 4'b0000, 20'd0, 1'b1, 4'b0000);
    for (int j = 0; j < 302; j++) begin
      cycle(1'b0, 1'b0, (j < 300) ? 4'b1111 : 4'b0000, 20'($urandom), 1'b1, 4'b0000);
      total++;
      if (bus.resp_mismatch !== (j >= 2)) begin
        bad++; $display("FAIL mm_flag[%0d] got=%b exp=%b", j, bus.resp_mismatch, (j >= 2));
      end
    end
    total++;
    if (bus.mismatch_cnt !== 8'd255) begin
      bad++; $display("FAIL mm_saturate got=%0d exp=255", bus.mismatch_cnt);
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_vec   = '0;
    bus.dp_out    = 1'b0;
`ifdef NT_SCHED_CHECK_EN
    bus.req_exp   = '0;
`endif
    model_reset();
    test_reset();
    test_single();
    test_reset_inflight();
    test_round_robin();
    test_drain();
    test_random();
`ifdef NT_SCHED_CHECK_EN
    test_mismatch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
